// File: rtl/vmask_popcount_seq_pkg.sv
// Shared types and helpers for the vcpop mask-walk sequencer.
package vmask_pkg;
   localparam int VLMAX_D = 1024;
   localparam int MASK_W  = 64;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   // Keep only bits [vl_mod-1:0] on a partial last word; otherwise pass everything.
   function automatic logic [MASK_W-1:0] tail_mask(input int vl_mod, input logic is_last);
      logic [MASK_W-1:0] m;
      m = '1;
      if (is_last && vl_mod != 0) m = (MASK_W'(1) << vl_mod) - MASK_W'(1);
      return m;
   endfunction

   function automatic int nwords(input int vl, input int w);
      return (vl + w - 1) / w;
   endfunction
endpackage

// File: rtl/vmask_popcount_seq_if.sv
// Request, mask-stream and result handshakes of the popcount sequencer.
interface vmask_popcount_seq_if #(
   parameter int REQ_DATA_WIDTH  = 64,
   parameter int RESP_DATA_WIDTH = 64,
   parameter int VL_W            = 11
);
   logic                       req_valid;
   logic                       req_ready;
   logic [VL_W-1:0]            req_vl;
   logic                       m_valid;
   logic                       m_ready;
   logic [REQ_DATA_WIDTH-1:0]  m_data;
   logic                       res_valid;
   logic                       res_ready;
   logic [RESP_DATA_WIDTH-1:0] res_data;
   logic                       busy;

   modport master (output req_valid, req_vl, m_valid, m_data, res_ready,
                   input  req_ready, m_ready, res_valid, res_data, busy);
   modport slave  (input  req_valid, req_vl, m_valid, m_data, res_ready,
                   output req_ready, m_ready, res_valid, res_data, busy);
endinterface

// File: rtl/vmask_popcount_seq_vadd.sv
// Popcount adder: out_vec = in_count + popcount(in_m0), one register stage.
module vAdd_mask #(
   parameter int REQ_DATA_WIDTH  = 64,
   parameter int RESP_DATA_WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [REQ_DATA_WIDTH-1:0]  in_m0,
   input  logic [RESP_DATA_WIDTH-1:0] in_count,
   output logic [RESP_DATA_WIDTH-1:0] out_vec
);
   logic [RESP_DATA_WIDTH-1:0] pc;

   always_comb begin
      pc = '0;
      for (int i = 0; i < REQ_DATA_WIDTH; i++) pc = pc + RESP_DATA_WIDTH'(in_m0[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           out_vec <= '0;
      else if (in_valid) out_vec <= in_count + pc;
   end
endmodule

// File: rtl/vmask_popcount_seq.sv
// Walks ceil(vl/W) mask words through vAdd_mask and returns the total set-bit count.
import vmask_pkg::*;

module vmask_popcount_seq #(
   parameter int REQ_DATA_WIDTH  = MASK_W,
   parameter int RESP_DATA_WIDTH = 64,
   parameter int VLMAX           = VLMAX_D
) (
   input logic             clk,
   input logic             rst_n,
   vmask_popcount_seq_if.slave bus
);
   localparam int VL_W = $clog2(VLMAX + 1);

   state_e                     state_q;
   logic [VL_W-1:0]            vl_q, nwords_q, wcnt_q, vl_clamp;
   logic [RESP_DATA_WIDTH-1:0] accum_q, out_vec, in_count;
   logic [REQ_DATA_WIDTH-1:0]  in_m0;
   logic [MASK_W-1:0]          tmask;
   logic                       pending_q, beat, is_last;

   assign vl_clamp = (bus.req_vl > VL_W'(VLMAX)) ? VL_W'(VLMAX) : bus.req_vl;
   assign beat     = (state_q == S_RUN) && bus.m_valid && bus.m_ready;
   assign is_last  = (wcnt_q == nwords_q - VL_W'(1));
   assign tmask    = tail_mask(int'(vl_q) % REQ_DATA_WIDTH, is_last);
   assign in_m0    = bus.m_data & REQ_DATA_WIDTH'(tmask);
   // Back-to-back beats take the previous sum straight from the adder register.
   assign in_count = pending_q ? out_vec : accum_q;
   assign bus.res_data = accum_q;

   vAdd_mask #(.REQ_DATA_WIDTH(REQ_DATA_WIDTH), .RESP_DATA_WIDTH(RESP_DATA_WIDTH)) u_vadd (
      .clk      (clk),
      .rst      (~rst_n),
      .in_valid (beat),
      .in_m0    (in_m0),
      .in_count (in_count),
      .out_vec  (out_vec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         accum_q       <= '0;
         pending_q     <= 1'b0;
         wcnt_q        <= '0;
         vl_q          <= '0;
         nwords_q      <= '0;
         bus.res_valid <= 1'b0;
         bus.m_ready   <= 1'b0;
         bus.busy      <= 1'b0;
         bus.req_ready <= 1'b1;
      end else begin
         case (state_q)
            S_IDLE: if (bus.req_valid) begin
               vl_q          <= vl_clamp;
               nwords_q      <= VL_W'(nwords(int'(vl_clamp), REQ_DATA_WIDTH));
               accum_q       <= '0;
               wcnt_q        <= '0;
               pending_q     <= 1'b0;
               bus.req_ready <= 1'b0;
               bus.busy      <= 1'b1;
               if (vl_clamp == '0) begin
                  state_q       <= S_DONE;
                  bus.res_valid <= 1'b1;
               end else begin
                  state_q     <= S_RUN;
                  bus.m_ready <= 1'b1;
               end
            end
            S_RUN: if (beat) begin
               pending_q <= 1'b1;
               wcnt_q    <= wcnt_q + VL_W'(1);
               if (is_last) begin
                  state_q     <= S_DRAIN;
                  bus.m_ready <= 1'b0;
               end
            end else begin
               accum_q   <= in_count;
               pending_q <= 1'b0;
            end
            S_DRAIN: begin
               accum_q       <= out_vec;
               pending_q     <= 1'b0;
               state_q       <= S_DONE;
               bus.res_valid <= 1'b1;
            end
            S_DONE: if (bus.res_ready) begin
               state_q       <= S_IDLE;
               bus.res_valid <= 1'b0;
               bus.busy      <= 1'b0;
               bus.req_ready <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vmask_popcount_seq.sv
// Directed plus random requests against a bit-level popcount reference model.
module tb_vmask_popcount_seq;
   localparam int W     = 64;
   localparam int VLMAX = 1024;
   localparam int VL_W  = 11;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   logic [W-1:0] words [16];

   always #5 clk = ~clk;

   vmask_popcount_seq_if #(.REQ_DATA_WIDTH(W), .RESP_DATA_WIDTH(64), .VL_W(VL_W)) bus ();

   vmask_popcount_seq #(.REQ_DATA_WIDTH(W), .RESP_DATA_WIDTH(64), .VLMAX(VLMAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Count of set bits among mask bit indices 0..vl-1 of the word stream.
   function automatic int model(input int vl);
      int s = 0;
      for (int i = 0; i < vl; i++) s += int'(words[i / W][i % W]);
      return s;
   endfunction

   task automatic do_req(input int req, input int gap, input int hold, input bit chk_lat);
      int vl, nw, exp_cnt, sent, extra, gcnt, lat;
      vl = (req > VLMAX) ? VLMAX : req;
      nw = (vl + W - 1) / W;
      exp_cnt = model(vl);
      sent = 0; extra = 0; gcnt = 0; lat = 0;
      @(negedge clk);
      chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1;
      bus.req_vl    = VL_W'(req);
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int n = 1; n <= 4000; n++) begin
         if (bus.res_valid) begin lat = n; break; end
         if (sent < nw && gcnt > 0) begin
            bus.m_valid = 1'b0;
            gcnt--;
         end else begin
            bus.m_valid = 1'b1;
            bus.m_data  = (sent < nw) ? words[sent] : 64'hDEAD_BEEF_F00D_CAFE;
         end
         if (bus.m_valid && bus.m_ready) begin
            if (sent < nw) begin sent++; gcnt = gap; end
            else extra++;
         end
         @(negedge clk);
      end
      bus.m_valid = 1'b0;
      chk("res_valid_seen", 64'(lat != 0), 64'd1);
      chk("beats", 64'(sent), 64'(nw));
      chk("extra_beats", 64'(extra), 64'd0);
      if (chk_lat) chk("latency", 64'(lat), 64'((nw == 0) ? 1 : nw + 2));
      chk("res_data", bus.res_data, 64'(exp_cnt));
      chk("busy_done", 64'(bus.busy), 64'd1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("hold_valid", 64'(bus.res_valid), 64'd1);
         chk("hold_data", bus.res_data, 64'(exp_cnt));
         chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
      end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk("post_req_ready", 64'(bus.req_ready), 64'd1);
      chk("post_res_valid", 64'(bus.res_valid), 64'd0);
      chk("post_busy", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_vl = '0;
      bus.m_valid = 1'b0;   bus.m_data = '0;
      bus.res_ready = 1'b0;
      #12;
      chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
      chk("rst_m_ready", 64'(bus.m_ready), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_res_data", bus.res_data, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_req_ready", 64'(bus.req_ready), 64'd1);

      words[0] = '1;
      do_req(64, 0, 0, 1'b1);

      words[0] = '1; words[1] = 64'h0F0F_0F0F_0F0F_0F0F; words[2] = 64'hFF;
      do_req(130, 0, 0, 1'b1);

      do_req(0, 0, 0, 1'b1);

      words[0] = 64'h1; words[1] = 64'h1; words[2] = 64'h1;
      do_req(192, 2, 5, 1'b0);

      // Abort a vl=256 request after one word with an asynchronous reset.
      for (int k = 0; k < 4; k++) words[k] = '1;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_vl = VL_W'(256);
      @(negedge clk);
      bus.req_valid = 1'b0; bus.m_valid = 1'b1; bus.m_data = words[0];
      @(negedge clk);
      bus.m_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_m_ready", 64'(bus.m_ready), 64'd0);
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_res_valid", 64'(bus.res_valid), 64'd0);
      chk("arst_req_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      words[0] = 64'hAAAA_AAAA_AAAA_AAAA;
      do_req(64, 0, 0, 1'b1);

      for (int k = 0; k < 16; k++) words[k] = '1;
      do_req(2000, 0, 1, 1'b1);

      for (int r = 0; r < 8; r++) begin
         int g;
         for (int k = 0; k < 16; k++) words[k] = {$urandom, $urandom};
         g = int'($urandom_range(0, 2));
         do_req(int'($urandom_range(0, 1100)), g, int'($urandom_range(0, 3)), g == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
